// File: rtl/gfx_mixer_pkg.sv
// Shared types and register-map constants for the graphics layer mixer.
// The collision accumulator is built only when GFX_MIXER_COLLISION_EN is defined.
package gfx_mixer_pkg;

  localparam int unsigned CTRL_PRIO_W     = 7;
  localparam int unsigned CTRL_FIELD_W    = 8;
  localparam int unsigned LAYER_CTRL_BASE = 0;

  localparam int unsigned CTRL_EN_BIT     = 0;
  localparam int unsigned CTRL_PRIO_LSB   = 1;
  localparam int unsigned CTRL_TRANSP_LSB = 8;
  localparam int unsigned CTRL_OFFSET_LSB = 16;

  // Fields sized for the widest legal configuration; unused upper bits stay zero.
  typedef struct packed {
    logic                    enable;
    logic [CTRL_PRIO_W-1:0]  prio;
    logic [CTRL_FIELD_W-1:0] transparent;
    logic [CTRL_FIELD_W-1:0] offset;
  } layer_ctrl_t;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic draw;
  } sync_t;

  function automatic int unsigned backdrop_addr(input int unsigned num_layers);
    return LAYER_CTRL_BASE + num_layers;
  endfunction

endpackage

// File: rtl/gfx_mixer_regs.sv
// Double-buffered control registers: bus writes hit shadow copies, new_frame
// copies shadow to active so a frame never sees a half-updated configuration.
module gfx_mixer_regs
  import gfx_mixer_pkg::*;
#(
  parameter int unsigned NUM_LAYERS    = 4,
  parameter int unsigned PIXEL_BITS    = 8,
  parameter int unsigned PRIO_BITS     = 2,
  parameter int unsigned REG_ADDR_BITS = 4
) (
  input  logic                               clk,
  input  logic                               aresetn,
  input  logic                               new_frame,
  input  logic                               reg_wen,
  input  logic [REG_ADDR_BITS-1:0]           reg_addr,
  input  logic [31:0]                        reg_wdata,
  output layer_ctrl_t [NUM_LAYERS-1:0]       active_ctrl,
  output logic [PIXEL_BITS-1:0]              active_backdrop
);

  layer_ctrl_t [NUM_LAYERS-1:0] shadow_q, shadow_d;
  layer_ctrl_t [NUM_LAYERS-1:0] active_q, active_d;
  logic [PIXEL_BITS-1:0]        bd_shadow_q, bd_shadow_d;
  logic [PIXEL_BITS-1:0]        bd_active_q, bd_active_d;

  logic unused_wdata;
  assign unused_wdata = ^reg_wdata;

  function automatic layer_ctrl_t decode_ctrl(input logic [31:0] wdata);
    layer_ctrl_t c;
    c.enable      = wdata[CTRL_EN_BIT];
    c.prio        = CTRL_PRIO_W'(wdata[CTRL_PRIO_LSB +: PRIO_BITS]);
    c.transparent = CTRL_FIELD_W'(wdata[CTRL_TRANSP_LSB +: PIXEL_BITS]);
    c.offset      = CTRL_FIELD_W'(wdata[CTRL_OFFSET_LSB +: PIXEL_BITS]);
    return c;
  endfunction

  function automatic layer_ctrl_t reset_ctrl(input int unsigned idx);
    layer_ctrl_t c;
    c.enable      = 1'b1;
    c.prio        = CTRL_PRIO_W'(idx % (2 ** PRIO_BITS));
    c.transparent = '0;
    c.offset      = '0;
    return c;
  endfunction

  // Active copies take the pre-write shadow when a write coincides with new_frame.
  always_comb begin
    shadow_d    = shadow_q;
    bd_shadow_d = bd_shadow_q;
    if (reg_wen) begin
      for (int i = 0; i < int'(NUM_LAYERS); i++) begin
        if (reg_addr == REG_ADDR_BITS'(LAYER_CTRL_BASE + i)) begin
          shadow_d[i] = decode_ctrl(reg_wdata);
        end
      end
      if (reg_addr == REG_ADDR_BITS'(backdrop_addr(NUM_LAYERS))) begin
        bd_shadow_d = reg_wdata[PIXEL_BITS-1:0];
      end
    end
    active_d    = new_frame ? shadow_q : active_q;
    bd_active_d = new_frame ? bd_shadow_q : bd_active_q;
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      for (int i = 0; i < int'(NUM_LAYERS); i++) begin
        shadow_q[i] <= reset_ctrl(i);
        active_q[i] <= reset_ctrl(i);
      end
      bd_shadow_q <= '0;
      bd_active_q <= '0;
    end else begin
      shadow_q    <= shadow_d;
      active_q    <= active_d;
      bd_shadow_q <= bd_shadow_d;
      bd_active_q <= bd_active_d;
    end
  end

  assign active_ctrl     = active_q;
  assign active_backdrop = bd_active_q;

endmodule

// File: rtl/gfx_layer_mixer.sv
// N-layer priority/transparency mixer producing a palette index with 3-cycle latency.
// Define GFX_MIXER_COLLISION_EN to build the per-frame collision accumulator.
module gfx_layer_mixer
  import gfx_mixer_pkg::*;
#(
  parameter int unsigned NUM_LAYERS    = 4,
  parameter int unsigned PIXEL_BITS    = 8,
  parameter int unsigned PRIO_BITS     = 2,
  parameter int unsigned REG_ADDR_BITS = 4
) (
  input  logic                             clk,
  input  logic                             aresetn,
  input  logic [NUM_LAYERS*PIXEL_BITS-1:0] layer_pixels,
  input  logic                             hsync_in,
  input  logic                             vsync_in,
  input  logic                             draw_in,
  input  logic                             new_frame,
  input  logic                             reg_wen,
  input  logic [REG_ADDR_BITS-1:0]         reg_addr,
  input  logic [31:0]                      reg_wdata,
  output logic [PIXEL_BITS-1:0]            pixel_out,
  output logic                             hsync_out,
  output logic                             vsync_out,
  output logic                             draw_out,
  output logic [NUM_LAYERS-1:0]            collision_flags
);

  layer_ctrl_t [NUM_LAYERS-1:0] active_ctrl;
  logic [PIXEL_BITS-1:0]        active_backdrop;

  gfx_mixer_regs #(
    .NUM_LAYERS    (NUM_LAYERS),
    .PIXEL_BITS    (PIXEL_BITS),
    .PRIO_BITS     (PRIO_BITS),
    .REG_ADDR_BITS (REG_ADDR_BITS)
  ) u_regs (
    .clk             (clk),
    .aresetn         (aresetn),
    .new_frame       (new_frame),
    .reg_wen         (reg_wen),
    .reg_addr        (reg_addr),
    .reg_wdata       (reg_wdata),
    .active_ctrl     (active_ctrl),
    .active_backdrop (active_backdrop)
  );

  logic [NUM_LAYERS-1:0]                  s1_mask_q, s1_mask_d;
  logic [NUM_LAYERS-1:0][PIXEL_BITS-1:0]  s1_idx_q, s1_idx_d;
  logic [NUM_LAYERS-1:0][CTRL_PRIO_W-1:0] s1_prio_q, s1_prio_d;
  logic [PIXEL_BITS-1:0]                  s1_bd_q, s1_bd_d;
  sync_t                                  s1_sync_q, s1_sync_d;
  logic [PIXEL_BITS-1:0]                  s2_pix_q, s2_pix_d;
  sync_t                                  s2_sync_q, s2_sync_d;
  logic [PIXEL_BITS-1:0]                  out_pix_q, out_pix_d;
  sync_t                                  out_sync_q, out_sync_d;
  logic                                   sel_found;
  logic [CTRL_PRIO_W-1:0]                 sel_prio;

  // S1: opacity and offset-adjusted index per layer, sampled with the active config.
  always_comb begin
    s1_mask_d = '0;
    s1_idx_d  = '0;
    s1_prio_d = '0;
    for (int i = 0; i < int'(NUM_LAYERS); i++) begin
      s1_mask_d[i] = active_ctrl[i].enable &&
                     (CTRL_FIELD_W'(layer_pixels[i*PIXEL_BITS +: PIXEL_BITS]) !=
                      active_ctrl[i].transparent);
      s1_idx_d[i]  = PIXEL_BITS'(CTRL_FIELD_W'(layer_pixels[i*PIXEL_BITS +: PIXEL_BITS]) +
                                 active_ctrl[i].offset);
      s1_prio_d[i] = active_ctrl[i].prio;
    end
    s1_bd_d   = active_backdrop;
    s1_sync_d = '{hsync: hsync_in, vsync: vsync_in, draw: draw_in};
  end

  // S2: strict less-than scan from layer 0 so ties go to the lower index.
  always_comb begin
    s2_pix_d  = s1_bd_q;
    sel_found = 1'b0;
    sel_prio  = '0;
    for (int i = 0; i < int'(NUM_LAYERS); i++) begin
      if (s1_mask_q[i] && (!sel_found || (s1_prio_q[i] < sel_prio))) begin
        sel_found = 1'b1;
        sel_prio  = s1_prio_q[i];
        s2_pix_d  = s1_idx_q[i];
      end
    end
    s2_sync_d = s1_sync_q;
  end

  // S3: blanking.
  always_comb begin
    out_pix_d  = s2_sync_q.draw ? s2_pix_q : '0;
    out_sync_d = s2_sync_q;
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      s1_mask_q  <= '0;
      s1_idx_q   <= '0;
      s1_prio_q  <= '0;
      s1_bd_q    <= '0;
      s1_sync_q  <= '0;
      s2_pix_q   <= '0;
      s2_sync_q  <= '0;
      out_pix_q  <= '0;
      out_sync_q <= '0;
    end else begin
      s1_mask_q  <= s1_mask_d;
      s1_idx_q   <= s1_idx_d;
      s1_prio_q  <= s1_prio_d;
      s1_bd_q    <= s1_bd_d;
      s1_sync_q  <= s1_sync_d;
      s2_pix_q   <= s2_pix_d;
      s2_sync_q  <= s2_sync_d;
      out_pix_q  <= out_pix_d;
      out_sync_q <= out_sync_d;
    end
  end

  assign pixel_out = out_pix_q;
  assign hsync_out = out_sync_q.hsync;
  assign vsync_out = out_sync_q.vsync;
  assign draw_out  = out_sync_q.draw;

`ifdef GFX_MIXER_COLLISION_EN
  logic [NUM_LAYERS-1:0] acc_q, acc_d;
  logic [NUM_LAYERS-1:0] coll_q, coll_d;
  logic                  multi_c;

  // A collision on the new_frame cycle lands in the freshly cleared accumulator.
  always_comb begin
    multi_c = (s1_mask_q & (s1_mask_q - NUM_LAYERS'(1))) != '0;
    acc_d   = new_frame ? '0 : acc_q;
    if (s1_sync_q.draw && multi_c) begin
      acc_d = acc_d | s1_mask_q;
    end
    coll_d  = new_frame ? acc_q : coll_q;
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      acc_q  <= '0;
      coll_q <= '0;
    end else begin
      acc_q  <= acc_d;
      coll_q <= coll_d;
    end
  end

  assign collision_flags = coll_q;
`else
  assign collision_flags = '0;
`endif

endmodule

// File: tb/tb_gfx_layer_mixer.sv
// Directed self-checking bench for gfx_layer_mixer (default parameters).
module tb_gfx_layer_mixer;

  localparam int unsigned NL = 4;
  localparam int unsigned PB = 8;
  localparam int unsigned AB = 4;

  logic               clk;
  logic               aresetn;
  logic [NL*PB-1:0]   layer_pixels;
  logic               hsync_in, vsync_in, draw_in;
  logic               new_frame;
  logic               reg_wen;
  logic [AB-1:0]      reg_addr;
  logic [31:0]        reg_wdata;
  logic [PB-1:0]      pixel_out;
  logic               hsync_out, vsync_out, draw_out;
  logic [NL-1:0]      collision_flags;

  int n_assert;
  int n_fail;
  logic [2:0] pat [8];
  logic [31:0] exp_coll;

  gfx_layer_mixer dut (
    .clk             (clk),
    .aresetn         (aresetn),
    .layer_pixels    (layer_pixels),
    .hsync_in        (hsync_in),
    .vsync_in        (vsync_in),
    .draw_in         (draw_in),
    .new_frame       (new_frame),
    .reg_wen         (reg_wen),
    .reg_addr        (reg_addr),
    .reg_wdata       (reg_wdata),
    .pixel_out       (pixel_out),
    .hsync_out       (hsync_out),
    .vsync_out       (vsync_out),
    .draw_out        (draw_out),
    .collision_flags (collision_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  function automatic logic [31:0] ctrl(input logic en, input logic [1:0] pr,
                                       input logic [7:0] tr, input logic [7:0] off);
    return {8'h00, off, tr, 5'b00000, pr, en};
  endfunction

  task automatic set_px(input logic [7:0] l0, input logic [7:0] l1,
                        input logic [7:0] l2, input logic [7:0] l3);
    layer_pixels = {l3, l2, l1, l0};
  endtask

  task automatic wr(input logic [AB-1:0] a, input logic [31:0] d);
    reg_wen   = 1'b1;
    reg_addr  = a;
    reg_wdata = d;
    tick();
    reg_wen   = 1'b0;
  endtask

  task automatic commit();
    new_frame = 1'b1;
    tick();
    new_frame = 1'b0;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    pat = '{3'b001, 3'b011, 3'b110, 3'b101, 3'b000, 3'b111, 3'b100, 3'b011};
`ifdef GFX_MIXER_COLLISION_EN
    exp_coll = 32'h0000000a;
`else
    exp_coll = 32'h0;
`endif
    aresetn = 1'b0; new_frame = 1'b0; reg_wen = 1'b0; reg_addr = '0; reg_wdata = '0;
    hsync_in = 1'b0; vsync_in = 1'b0; draw_in = 1'b0;
    set_px(8'd0, 8'd0, 8'd0, 8'd0);
    ticks(2);
    check("rst_pixel", 32'(pixel_out), 32'h0);
    check("rst_hsync", 32'(hsync_out), 32'h0);
    check("rst_vsync", 32'(vsync_out), 32'h0);
    check("rst_draw",  32'(draw_out),  32'h0);
    check("rst_coll",  32'(collision_flags), 32'h0);
    aresetn = 1'b1;

    // Reset defaults: L0 prio 0 beats L1 prio 1; first result after 3 edges.
    draw_in = 1'b1;
    set_px(8'd5, 8'd7, 8'd0, 8'd0);
    ticks(2);
    check("lat_not_yet", 32'(pixel_out), 32'h0);
    tick();
    check("default_prio", 32'(pixel_out), 32'd5);

    // Tie at prio 0 goes to lower index, then L0 demoted to prio 3.
    wr(4'd1, ctrl(1'b1, 2'd0, 8'd0, 8'd0));
    commit(); ticks(3);
    check("tie_break", 32'(pixel_out), 32'd5);
    wr(4'd0, ctrl(1'b1, 2'd3, 8'd0, 8'd0));
    commit(); ticks(3);
    check("prio_win", 32'(pixel_out), 32'd7);

    // Transparency + offset wrap on L2.
    wr(4'd2, ctrl(1'b1, 2'd2, 8'd9, 8'd250));
    commit();
    set_px(8'd0, 8'd0, 8'd10, 8'd0);
    ticks(3);
    check("offset_wrap", 32'(pixel_out), 32'd4);

    // Backdrop, no offset; out-of-range addresses ignored.
    wr(4'd4, 32'h0000_0033);
    commit();
    set_px(8'd0, 8'd0, 8'd9, 8'd0);
    ticks(3);
    check("backdrop", 32'(pixel_out), 32'h33);
    wr(4'd5, 32'h0000_0077);
    wr(4'd15, 32'h0000_0055);
    commit(); ticks(3);
    check("high_addr_ignored", 32'(pixel_out), 32'h33);

    // Shadow write has no effect until new_frame.
    set_px(8'd5, 8'd0, 8'd9, 8'd0);
    ticks(3);
    check("l0_only", 32'(pixel_out), 32'd5);
    wr(4'd0, ctrl(1'b0, 2'd3, 8'd0, 8'd0));
    ticks(3);
    check("no_commit_yet", 32'(pixel_out), 32'd5);
    commit(); ticks(3);
    check("l0_disabled", 32'(pixel_out), 32'h33);

    // Write coinciding with new_frame commits only at the following new_frame.
    reg_wen = 1'b1; reg_addr = 4'd0; reg_wdata = ctrl(1'b1, 2'd3, 8'd0, 8'd0);
    new_frame = 1'b1;
    tick();
    reg_wen = 1'b0; new_frame = 1'b0;
    ticks(3);
    check("same_cycle_old", 32'(pixel_out), 32'h33);
    commit(); ticks(3);
    check("same_cycle_new", 32'(pixel_out), 32'd5);

    // Sync/blank pattern reappears exactly 3 edges later.
    for (int c = 0; c < 10; c++) begin
      if (c < 8) begin
        {hsync_in, vsync_in, draw_in} = pat[c];
        set_px(8'(c + 1), 8'd0, 8'd9, 8'd0);
      end else begin
        {hsync_in, vsync_in, draw_in} = 3'b000;
      end
      tick();
      if (c >= 2) begin
        check($sformatf("hsync%0d", c - 2), 32'(hsync_out), 32'(pat[c-2][2]));
        check($sformatf("vsync%0d", c - 2), 32'(vsync_out), 32'(pat[c-2][1]));
        check($sformatf("draw%0d",  c - 2), 32'(draw_out),  32'(pat[c-2][0]));
        check($sformatf("blank%0d", c - 2), 32'(pixel_out),
              pat[c-2][0] ? 32'(c - 1) : 32'h0);
      end
    end

    // Collision: L1 and L3 overlap once, then a clean frame.
    draw_in = 1'b1;
    set_px(8'd0, 8'd0, 8'd9, 8'd0);
    commit();
    set_px(8'd0, 8'd3, 8'd9, 8'd4);
    tick();
    set_px(8'd0, 8'd0, 8'd9, 8'd0);
    ticks(3);
    commit();
    check("coll_flags", 32'(collision_flags), exp_coll);
    ticks(3);
    commit();
    check("coll_clear", 32'(collision_flags), 32'h0);

    // Mid-frame reset discards in-flight pixels and restores default config.
    set_px(8'd5, 8'd7, 8'd9, 8'd0);
    ticks(3);
    check("pre_reset", 32'(pixel_out), 32'd7);
    aresetn = 1'b0;
    tick();
    aresetn = 1'b1;
    check("mid_rst_pixel", 32'(pixel_out), 32'h0);
    check("mid_rst_draw",  32'(draw_out),  32'h0);
    check("mid_rst_coll",  32'(collision_flags), 32'h0);
    ticks(2);
    check("flushed", 32'(pixel_out), 32'h0);
    tick();
    check("post_rst_default", 32'(pixel_out), 32'd5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
